// File: rtl/vga_capture.sv
// vga_capture: receive side of a VGA-style raster link.
// Samples hsync/vsync/RGB on pix_en, tracks raster position, and streams the
// active-window pixels with coordinates and frame/line markers through a
// small first-word-fall-through FIFO.
module vga_capture #(
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned H_BACK     = 148,
    parameter int unsigned V_ACTIVE   = 1080,
    parameter int unsigned V_BACK     = 36,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        locked,
    output logic        overflow,
    output logic [11:0] line_len
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [11:0] CNT_MAX  = '1;
    localparam logic [11:0] H_LO     = 12'(H_BACK);
    localparam logic [11:0] H_HI     = 12'(H_BACK + H_ACTIVE);
    localparam logic [11:0] V_LO     = 12'(V_BACK);
    localparam logic [11:0] V_HI     = 12'(V_BACK + V_ACTIVE);
    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [AW:0] PTR_ONE  = 1;

    typedef struct packed {
        logic [23:0] rgb;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
    } entry_t;

    // Normalised sync levels: 1 means asserted regardless of polarity.
    logic        hs_now, vs_now;
    logic        hs_prev, vs_prev;
    logic        h_trail, h_lead, v_trail;
    logic [11:0] h_cnt, v_cnt, h_next, v_next;
    logic        lock_next, sample_active;
    logic [10:0] x_next, y_next;

    // Sample stage: holds the entry registered on pix_en until it is pushed.
    logic        st_valid;
    entry_t      st_entry;

    logic [11:0] ll_cnt;
    logic        seen_lead;
    logic [12:0] ll_sum;

    entry_t      mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, do_push, do_pop;
    entry_t      head;

    assign hs_now = (hsync_in == HS_POL);
    assign vs_now = (vsync_in == VS_POL);

    // Edge detection and next raster position for the sample being taken now.
    always_comb begin
        h_trail = hs_prev & ~hs_now;
        h_lead  = ~hs_prev & hs_now;
        v_trail = vs_prev & ~vs_now;

        if (h_trail)
            h_next = '0;
        else if (h_cnt == CNT_MAX)
            h_next = CNT_MAX;
        else
            h_next = h_cnt + 12'd1;

        // vsync clear takes priority over the per-line increment
        if (v_trail)
            v_next = '0;
        else if (h_trail && (v_cnt != CNT_MAX))
            v_next = v_cnt + 12'd1;
        else
            v_next = v_cnt;

        lock_next     = locked | v_trail;
        sample_active = lock_next
                        && (h_next >= H_LO) && (h_next < H_HI)
                        && (v_next >= V_LO) && (v_next < V_HI);
        x_next = 11'(h_next - H_LO);
        y_next = 11'(v_next - V_LO);
        ll_sum = {1'b0, ll_cnt} + 13'd1;
    end

    // Input stage: register the sample, advance raster counters and lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            locked   <= 1'b0;
            st_valid <= 1'b0;
            st_entry <= '0;
        end else begin
            st_valid <= pix_en & sample_active;
            if (pix_en) begin
                hs_prev      <= hs_now;
                vs_prev      <= vs_now;
                h_cnt        <= h_next;
                v_cnt        <= v_next;
                locked       <= lock_next;
                st_entry.rgb <= {red_in, green_in, blue_in};
                st_entry.x   <= x_next;
                st_entry.y   <= y_next;
                st_entry.sof <= (x_next == '0) && (y_next == '0);
                st_entry.eol <= (x_next == X_LAST);
            end
        end
    end

    // Line period measurement between hsync leading edges, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ll_cnt    <= '0;
            seen_lead <= 1'b0;
            line_len  <= '0;
        end else if (pix_en) begin
            if (h_lead) begin
                if (seen_lead)
                    line_len <= ll_sum[12] ? CNT_MAX : ll_sum[11:0];
                seen_lead <= 1'b1;
                ll_cnt    <= '0;
            end else if (ll_cnt != CNT_MAX) begin
                ll_cnt <= ll_cnt + 12'd1;
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = ~empty & pix_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = st_valid & (~full | do_pop);

    // FIFO storage, cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= st_entry;
        end
    end

    // FIFO pointers and sticky drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (st_valid && full && !do_pop)
                overflow <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign pix_valid = ~empty;
    assign pix_data  = head.rgb;
    assign pix_x     = head.x;
    assign pix_y     = head.y;
    assign pix_sof   = head.sof;
    assign pix_eol   = head.eol;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: random-ish raster stimulus, reference model of the
// capture rules feeding per-DUT expected queues, and monitors that pop on
// each output handshake. A second instance uses active-low hsync.
module tb_vga_capture;

    localparam int HA = 8, HB = 2, VA = 4, VB = 1, DEPTH = 4;
    localparam int LINE = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic        hsync_inv;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        pix_ready = 1'b1;

    logic        v_a, sof_a, eol_a, lk_a, ov_a;
    logic [23:0] d_a;
    logic [10:0] x_a, y_a;
    logic [11:0] ll_a;
    logic        v_b, sof_b, eol_b, lk_b, ov_b;
    logic [23:0] d_b;
    logic [10:0] x_b, y_b;
    logic [11:0] ll_b;

    assign hsync_inv = ~hsync;

    always #5 clk = ~clk;

    vga_capture #(.H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB),
                  .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync), .vsync_in(vsync),
        .red_in(r), .green_in(g), .blue_in(b), .pix_valid(v_a), .pix_ready(pix_ready),
        .pix_data(d_a), .pix_x(x_a), .pix_y(y_a), .pix_sof(sof_a), .pix_eol(eol_a),
        .locked(lk_a), .overflow(ov_a), .line_len(ll_a));

    vga_capture #(.H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB),
                  .HS_POL(1'b0), .VS_POL(1'b1), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync_inv), .vsync_in(vsync),
        .red_in(r), .green_in(g), .blue_in(b), .pix_valid(v_b), .pix_ready(pix_ready),
        .pix_data(d_b), .pix_x(x_b), .pix_y(y_b), .pix_sof(sof_b), .pix_eol(eol_b),
        .locked(lk_b), .overflow(ov_b), .line_len(ll_b));

    typedef struct packed {
        logic [23:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    pix_t exp_a[$];
    pix_t exp_b[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   m_hs, m_vs, m_lk, m_ov, m_seen, pend_v, m_pop, m_ht, m_vt, m_hl;
    int   m_h, m_v, m_occ, m_ll, m_llc;
    pix_t pend;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hs = 0; m_vs = 0; m_lk = 0; m_ov = 0; m_seen = 0; pend_v = 0;
            m_h = 0; m_v = 0; m_occ = 0; m_ll = 0; m_llc = 0;
            exp_a.delete();
            exp_b.delete();
        end else begin
            // pixel taken last sample enters the FIFO now, unless full with no pop
            m_pop = (m_occ > 0) && pix_ready;
            if (pend_v) begin
                if (m_occ < DEPTH || m_pop) begin
                    exp_a.push_back(pend);
                    exp_b.push_back(pend);
                    m_occ++;
                end else begin
                    m_ov = 1;
                end
            end
            if (m_pop) m_occ--;
            pend_v = 0;
            if (pix_en) begin
                m_ht = m_hs && !hsync;
                m_vt = m_vs && !vsync;
                m_hl = !m_hs && hsync;
                m_h  = m_ht ? 0 : (m_h < 4095 ? m_h + 1 : 4095);
                if (m_vt) m_v = 0;
                else if (m_ht && m_v < 4095) m_v++;
                if (m_vt) m_lk = 1;
                if (m_lk && m_h >= HB && m_h < HB + HA && m_v >= VB && m_v < VB + VA) begin
                    pend_v   = 1;
                    pend.d   = {r, g, b};
                    pend.x   = 11'(m_h - HB);
                    pend.y   = 11'(m_v - VB);
                    pend.sof = (m_h == HB) && (m_v == VB);
                    pend.eol = (m_h == HB + HA - 1);
                end
                if (m_hl) begin
                    if (m_seen) m_ll = (m_llc + 1 > 4095) ? 4095 : m_llc + 1;
                    m_seen = 1;
                    m_llc  = 0;
                end else if (m_llc < 4095) begin
                    m_llc++;
                end
                m_hs = hsync;
                m_vs = vsync;
            end
        end
    end

    // ---------------- monitors ----------------
    int          n_pix = 0, n_sof = 0, n_eol = 0;
    bit          held_a = 0, held_b = 0;
    logic [47:0] hv_a, hv_b;
    pix_t        e_a, e_b;

    always @(negedge clk) begin
        check("valid_a", v_a, m_occ > 0);
        check("locked_a", lk_a, m_lk);
        check("overflow_a", ov_a, m_ov);
        check("line_len_a", ll_a, 12'(m_ll));
        if (held_a && v_a) check("hold_a", {d_a, x_a, y_a, sof_a, eol_a}, hv_a);
        if (v_a && pix_ready) begin
            if (exp_a.size() == 0) begin
                check("unexpected_a", 1, 0);
            end else begin
                e_a = exp_a.pop_front();
                check("pix_a", {d_a, x_a, y_a, sof_a, eol_a}, e_a);
            end
            n_pix++;
            n_sof += int'(sof_a);
            n_eol += int'(eol_a);
        end
        held_a = reset && v_a && !pix_ready;
        hv_a   = {d_a, x_a, y_a, sof_a, eol_a};
    end

    always @(negedge clk) begin
        check("valid_b", v_b, m_occ > 0);
        check("locked_b", lk_b, m_lk);
        check("overflow_b", ov_b, m_ov);
        check("line_len_b", ll_b, 12'(m_ll));
        if (held_b && v_b) check("hold_b", {d_b, x_b, y_b, sof_b, eol_b}, hv_b);
        if (v_b && pix_ready) begin
            if (exp_b.size() == 0) begin
                check("unexpected_b", 1, 0);
            end else begin
                e_b = exp_b.pop_front();
                check("pix_b", {d_b, x_b, y_b, sof_b, eol_b}, e_b);
            end
        end
        held_b = reset && v_b && !pix_ready;
        hv_b   = {d_b, x_b, y_b, sof_b, eol_b};
    end

    // ---------------- stimulus ----------------
    bit pp_mode = 0, rand_ready = 0, rand_rgb = 0;
    int np0, ns0, ne0;

    task automatic mark();
        np0 = n_pix; ns0 = n_sof; ne0 = n_eol;
    endtask

    // one pix_en sample, then 'gap' idle cycles (negative gap = random 0..2)
    task automatic sample(input bit hs, input bit vs, input logic [23:0] rgb, input int gap);
        int gg;
        hsync = hs; vsync = vs; {r, g, b} = rgb; pix_en = 1'b1;
        if (pp_mode && m_occ >= DEPTH) pix_ready = 1'b1;
        if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        pix_en = 1'b0;
        gg = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (gg) begin
            r = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // 14-sample line: 2 sync samples, 2 back porch, 8 active, 2 front porch
    task automatic drive_line(input bit vs, input int yl, input int gap);
        logic [23:0] rgb;
        for (int s = 0; s < LINE; s++) begin
            if (s >= 4 && s < 12 && !rand_rgb) rgb = {8'(yl), 8'(s - 4), 8'h55};
            else rgb = 24'($urandom);
            sample(s < 2, vs, rgb, gap);
        end
    endtask

    task automatic drive_frame(input int gap);
        drive_line(1'b1, 0, gap);
        for (int y = 0; y < VA; y++) drive_line(1'b0, y, gap);
        drive_line(1'b0, 0, gap);
    endtask

    task automatic drain();
        pix_ready = 1'b1;
        rand_ready = 0;
        for (int i = 0; i < 60 && m_occ > 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_a", exp_a.size(), 0);
        check("drain_b", exp_b.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_a", {v_a, d_a, x_a, y_a, sof_a, eol_a, lk_a, ov_a, ll_a}, '0);
        check("reset_out_b", {v_b, d_b, x_b, y_b, sof_b, eol_b, lk_b, ov_b, ll_b}, '0);
        reset = 1'b1;

        // pre-lock: lines without any vsync produce nothing
        mark();
        for (int l = 0; l < 3; l++) drive_line(1'b0, l, 1);
        check("prelock_count", n_pix - np0, 0);
        check("prelock_locked", lk_a, 0);

        // nominal frame, pix_en every other cycle
        mark();
        drive_frame(1);
        drain();
        check("nominal_count", n_pix - np0, 32);
        check("nominal_sof", n_sof - ns0, 1);
        check("nominal_eol", n_eol - ne0, 4);
        check("nominal_ovf", ov_a, 0);
        check("nominal_lock", lk_a, 1);
        check("line_len_b_14", ll_b, 14);

        // full FIFO with simultaneous push and pop: no overflow
        mark();
        drive_line(1'b1, 0, 0);
        pix_ready = 1'b0;
        pp_mode = 1;
        drive_line(1'b0, 0, 0);
        pp_mode = 0;
        pix_ready = 1'b1;
        for (int y = 1; y < VA; y++) drive_line(1'b0, y, 0);
        drive_line(1'b0, 0, 0);
        drain();
        check("pushpop_count", n_pix - np0, 32);
        check("pushpop_ovf", ov_a, 0);

        // backpressure for a whole line: 4 held, rest dropped
        mark();
        drive_line(1'b1, 0, 1);
        pix_ready = 1'b0;
        drive_line(1'b0, 0, 1);
        check("bp_ovf_a", ov_a, 1);
        check("bp_ovf_b", ov_b, 1);
        check("bp_none_out", n_pix - np0, 0);
        pix_ready = 1'b1;
        for (int y = 1; y < VA; y++) drive_line(1'b0, y, 1);
        drive_line(1'b0, 0, 1);
        drain();
        check("bp_count", n_pix - np0, 28);

        // async reset mid-line with 3 pixels queued
        drive_line(1'b1, 0, 1);
        pix_ready = 1'b0;
        for (int s = 0; s < LINE && m_occ < 3; s++)
            sample(s < 2, 1'b0, {8'd0, 8'(s - 4), 8'h55}, 1);
        check("pre_reset_valid", v_a, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_a", {v_a, lk_a, ov_a}, 3'b000);
        check("mid_reset_b", {v_b, lk_b, ov_b}, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        pix_ready = 1'b1;
        hsync = 1'b0; vsync = 1'b0;
        mark();
        for (int l = 0; l < 2; l++) drive_line(1'b0, l, 1);
        check("post_reset_none", n_pix - np0, 0);
        check("post_reset_unlocked", lk_a, 0);
        mark();
        drive_frame(1);
        drain();
        check("post_reset_frame", n_pix - np0, 32);

        // randomized gaps, backpressure and colours
        rand_rgb = 1;
        for (int f = 0; f < 3; f++) begin
            rand_ready = 1;
            drive_frame(-1);
        end
        drain();
        rand_rgb = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive end of the VGA-style raster interface: samples an incoming hsync/vsync/RGB pixel stream and recovers the active-window pixels.
- Emits those pixels with x/y coordinates and frame/line markers over a valid/ready stream.
- A small FIFO decouples the pixel rate from the downstream consumer, e.g. the text-extraction frame writer.
- One clock domain; the source pixel rate is indicated by a pixel-enable strobe.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_BACK, 148, pix_en samples from hsync trailing edge to first active pixel
- V_ACTIVE, 1080, active lines per frame
- V_BACK, 36, lines from vsync trailing edge to first active line
- HS_POL, 1, hsync asserted level (1 = active-high)
- VS_POL, 1, vsync asserted level
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pix_en  input  1  one-cycle strobe: sample sync/RGB inputs this cycle
- hsync_in  input  1  horizontal sync
- vsync_in  input  1  vertical sync
- red_in  input  8  red component
- green_in  input  8  green component
- blue_in  input  8  blue component
- pix_valid  output  1  output pixel available
- pix_ready  input  1  consumer accepts pixel
- pix_data  output  24  {red, green, blue}
- pix_x  output  11  column within active window
- pix_y  output  11  row within active window
- pix_sof  output  1  marks pixel (0,0)
- pix_eol  output  1  marks x = H_ACTIVE-1
- locked  output  1  a vsync trailing edge has been seen
- overflow  output  1  sticky: pixel dropped because FIFO was full
- line_len  output  12  measured pix_en count between hsync leading edges, saturating at 4095

Behaviour:
- Reset (reset=0, async): all outputs 0. Counters, FIFO and edge-detect history are cleared. Sync history is loaded with the deasserted level.
- Input stage: on each clk where pix_en=1, register the sync and RGB inputs, then normalise syncs by HS_POL/VS_POL. Edges are detected between consecutive pix_en samples only. With pix_en=0 all state holds.
- Horizontal counter h_cnt (12 bit):
  - Cleared to 0 on the hsync trailing edge.
  - Otherwise increments per sample and saturates at 4095.
- Vertical counter v_cnt (12 bit):
  - Cleared to 0 on the vsync trailing edge.
  - Otherwise increments on each hsync trailing edge and saturates.
  - If both trailing edges occur on the same sample, the vsync clear wins (no increment).
- locked: set on the first vsync trailing edge; cleared only by reset.
- Active sample: requires all of locked=1, H_BACK <= h_cnt < H_BACK+H_ACTIVE, and V_BACK <= v_cnt < V_BACK+V_ACTIVE.
  - x = h_cnt-H_BACK; y = v_cnt-V_BACK.
  - sof = (x==0 && y==0); eol = (x==H_ACTIVE-1).
- Push rules:
  - An active sample pushes {RGB, x, y, sof, eol} into the FIFO on the clk edge after it was registered.
  - If the FIFO is full, the sample is dropped and overflow is set (sticky until reset). The FIFO contents are unchanged.
- Latency: a pixel registered at edge N is visible with pix_valid=1 after edge N+1 when the FIFO was empty.
- Output handshake:
  - FWFT: pix_valid = FIFO not empty; outputs reflect the head entry.
  - Transfer occurs on a clk edge with pix_valid && pix_ready.
  - While pix_valid && !pix_ready, all pix_* outputs hold stable.
  - Push and pop in the same cycle are allowed: occupancy is unchanged, and this is not an overflow even when full.
- line_len: counts samples between consecutive hsync leading edges and updates at each leading edge. It holds its value in between; the first update occurs after the second leading edge.
- Malformed timing:
  - A short line (hsync before H_ACTIVE samples) simply ends capture; no eol is emitted and there is no padding.
  - A vsync mid-frame restarts y at the next trailing edge.
  - Pixels after V_BACK+V_ACTIVE lines are ignored.
- Reset mid-operation: the FIFO is flushed, pix_valid drops immediately, and locked must be reacquired.

Test Plan:
All tests use H_ACTIVE=8, H_BACK=2, V_ACTIVE=4, V_BACK=1, HS_POL=VS_POL=1, FIFO_DEPTH=4.
- Nominal frame: pix_en every other cycle, pix_ready=1, RGB = {y,x,0x55}, full frame after one vsync. Required response:
  - Exactly 32 pixels in raster order with x 0..7 and y 0..3.
  - pix_sof only on (0,0); pix_eol on each x=7.
  - overflow=0, locked=1.
- Pre-lock: a frame driven before any vsync pulse produces no pix_valid. Capture starts only after the vsync trailing edge.
- Backpressure: pix_ready=0 for an entire line.
  - First 4 pixels are held with stable pix_data; overflow=1.
  - After pix_ready=1 those 4 pixels (x=0..3) emerge in order.
  - The next line is captured normally.
- Simultaneous push/pop while the FIFO is full (pix_ready=1 on a push cycle): occupancy stays 4 and overflow remains 0.
- Polarity and measurement: HS_POL=0 with inverted hsync and a 14-sample line period. Required: same pixel output as nominal, and line_len=14 after the second hsync leading edge.
- Async reset asserted mid-line with 3 pixels in the FIFO: pix_valid, locked and overflow go to 0 immediately. After release there is no output until the next vsync trailing edge.
